// File: rtl/piso_pkg.sv
// ---------------------------------------------------------------------------
// piso_pkg
// Shared definitions for the parallel-in/serial-out serializer slice.
//   - state_t        : FSM state encoding (IDLE / SHIFT / PARITY)
//   - DEFAULT_D_SIZE : default word width in bits
//   - cntWidth()     : width of the bit counter for a given word width
// Optional feature macro used by the slice: PISO_PARITY_EN (the PARITY state
// is only reachable when it is defined).
// ---------------------------------------------------------------------------
package piso_pkg;

    // Frame sequencing states. PARITY is only entered when the parity
    // feature is compiled in, but the encoding is fixed either way.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        PARITY = 2'd2
    } state_t;

    localparam int DEFAULT_D_SIZE = 4;

    // Counter width needed to count data bits 0 .. dSize-1. A one-bit word is
    // not a legal configuration, but a width of at least 1 keeps the
    // arithmetic well formed.
    function automatic int cntWidth(input int dSize);
        return (dSize > 1) ? $clog2(dSize) : 1;
    endfunction

endpackage

// File: rtl/piso_bit_counter.sv
// ---------------------------------------------------------------------------
// piso_bit_counter
// Counts the data bits of the frame currently on the serial line and flags
// the last one.
// Ports:
//   clk        : system clock, rising edge
//   rst        : asynchronous reset, active-high (count returns to 0)
//   clear_i    : a new word is being loaded; count restarts at 0
//   enable_i   : advance to the next data bit
//   terminal_o : count has reached D_SIZE-1 (last data bit of the frame)
// Macro: none (PISO_PARITY_EN is handled entirely in the top level).
// ---------------------------------------------------------------------------
module piso_bit_counter
    import piso_pkg::*;
#(
    parameter int D_SIZE = DEFAULT_D_SIZE
) (
    input  logic clk,
    input  logic rst,
    input  logic clear_i,
    input  logic enable_i,
    output logic terminal_o
);

    localparam int CW = cntWidth(D_SIZE);
    localparam logic [CW-1:0] LAST_BIT = CW'(D_SIZE - 1);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    // Next count: a load always restarts the frame at bit 0 and takes
    // priority over advancing, otherwise step forward only when enabled.
    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (enable_i) begin
            count_d = count_q + CW'(1);
        end
    end

    // Counter register; reset puts us back at bit 0 so a frame aborted by
    // reset leaves no trace in the count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign terminal_o = (count_q == LAST_BIT);

endmodule

// File: rtl/piso_serializer.sv
// ---------------------------------------------------------------------------
// piso_serializer
// Parallel-in/serial-out serializer. Accepts a D_SIZE-bit word over a
// valid/ready handshake and shifts it out one bit per clock with a
// qualifying serial_valid strobe. Consecutive words follow with no idle
// bubble so a downstream SIPO sees a continuous bit stream.
// Parameters:
//   D_SIZE    : word width in bits (>= 2)
//   MSB_FIRST : 1 = bit D_SIZE-1 leaves first, 0 = bit 0 leaves first
// Ports:
//   clk          : system clock, rising edge
//   rst          : asynchronous reset, active-high
//   in_data      : parallel word to serialize
//   in_valid     : in_data is valid this cycle
//   in_ready     : a word will be accepted at the next rising edge
//   serial_out   : current serial bit (flop output)
//   serial_valid : serial_out carries a frame bit this cycle
//   frame_done   : one-cycle pulse on the last bit of a frame
// Macro: PISO_PARITY_EN - when defined, each frame is followed by one even
// parity bit (XOR of the word) and the frame grows to D_SIZE+1 bits.
// ---------------------------------------------------------------------------
module piso_serializer
    import piso_pkg::*;
#(
    parameter int D_SIZE    = DEFAULT_D_SIZE,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [D_SIZE-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              serial_out,
    output logic              serial_valid,
    output logic              frame_done
);

    state_t            state_q;
    state_t            state_d;
    logic [D_SIZE-1:0] shiftReg_q;
    logic [D_SIZE-1:0] shiftReg_d;
    logic [D_SIZE-1:0] shiftedWord;
    logic              cntClear;
    logic              cntEnable;
    logic              lastBit;
    logic              inReady;
    logic              accept;

`ifdef PISO_PARITY_EN
    logic              parity_q;
    logic              parity_d;
    logic [D_SIZE-1:0] parityWord;
`endif

    // Bit position tracking lives in its own small counter so the FSM only
    // has to ask "is this the last data bit?".
    piso_bit_counter #(
        .D_SIZE (D_SIZE)
    ) u_bitCounter (
        .clk        (clk),
        .rst        (rst),
        .clear_i    (cntClear),
        .enable_i   (cntEnable),
        .terminal_o (lastBit)
    );

    // The outgoing bit always sits at one fixed end of the shift register
    // (top for MSB-first, bottom for LSB-first). Advancing moves the next
    // bit into that slot and back-fills with zero, which also leaves the
    // register clean once a frame has fully drained. The parity bit, when
    // present, is simply parked in the same output slot for its cycle.
    always_comb begin
        if (MSB_FIRST) begin
            shiftedWord = {shiftReg_q[D_SIZE-2:0], 1'b0};
        end else begin
            shiftedWord = {1'b0, shiftReg_q[D_SIZE-1:1]};
        end
`ifdef PISO_PARITY_EN
        if (MSB_FIRST) begin
            parityWord = {parity_q, {(D_SIZE-1){1'b0}}};
        end else begin
            parityWord = {{(D_SIZE-1){1'b0}}, parity_q};
        end
`endif
    end

    // Handshake: a word can be taken whenever the line is idle, or in the
    // final cycle of the current frame so the next word follows without a
    // gap. With parity that final cycle is the parity bit, not the last
    // data bit. Ready is held low throughout reset.
    always_comb begin
        inReady = 1'b0;
        case (state_q)
            IDLE:    inReady = 1'b1;
`ifdef PISO_PARITY_EN
            PARITY:  inReady = 1'b1;
`else
            SHIFT:   inReady = lastBit;
`endif
            default: inReady = 1'b0;
        endcase
        if (rst) begin
            inReady = 1'b0;
        end
    end

    assign accept = in_valid & inReady;

    // Next-state and datapath control. A load copies the word into the
    // shift register and restarts the counter; the first bit then appears
    // on serial_out in the following cycle. At the end of a frame we either
    // chain straight into the next word or drop back to IDLE with a zeroed
    // register so serial_out reads 0 while idle.
    always_comb begin
        state_d    = state_q;
        shiftReg_d = shiftReg_q;
        cntClear   = 1'b0;
        cntEnable  = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d    = SHIFT;
                    shiftReg_d = in_data;
                    cntClear   = 1'b1;
                end
            end
            SHIFT: begin
                if (!lastBit) begin
                    shiftReg_d = shiftedWord;
                    cntEnable  = 1'b1;
                end else begin
`ifdef PISO_PARITY_EN
                    state_d    = PARITY;
                    shiftReg_d = parityWord;
`else
                    if (accept) begin
                        state_d    = SHIFT;
                        shiftReg_d = in_data;
                        cntClear   = 1'b1;
                    end else begin
                        state_d    = IDLE;
                        shiftReg_d = '0;
                    end
`endif
                end
            end
`ifdef PISO_PARITY_EN
            PARITY: begin
                if (accept) begin
                    state_d    = SHIFT;
                    shiftReg_d = in_data;
                    cntClear   = 1'b1;
                end else begin
                    state_d    = IDLE;
                    shiftReg_d = '0;
                end
            end
`endif
            default: begin
                state_d    = IDLE;
                shiftReg_d = '0;
            end
        endcase
    end

`ifdef PISO_PARITY_EN
    // Even parity of the word is captured at load time, since the word
    // itself is shifted away bit by bit before the parity cycle arrives.
    always_comb begin
        parity_d = parity_q;
        if (cntClear) begin
            parity_d = ^in_data;
        end
    end

    // Parity holding register; cleared with the rest of the frame state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            parity_q <= 1'b0;
        end else begin
            parity_q <= parity_d;
        end
    end
`endif

    // State and shift register. Reset aborts any frame in flight at once:
    // the register clears and the state returns to IDLE, so serial_valid
    // and frame_done drop without completing the frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            shiftReg_q <= '0;
        end else begin
            state_q    <= state_d;
            shiftReg_q <= shiftReg_d;
        end
    end

    // Outputs are taken straight from the state and shift register flops.
    // frame_done marks the final bit on the line: the last data bit, or
    // the parity bit when that feature is present.
    assign in_ready     = inReady;
    assign serial_out   = MSB_FIRST ? shiftReg_q[D_SIZE-1] : shiftReg_q[0];
    assign serial_valid = (state_q != IDLE);
`ifdef PISO_PARITY_EN
    assign frame_done   = (state_q == PARITY);
`else
    assign frame_done   = (state_q == SHIFT) && lastBit;
`endif

endmodule

// File: tb/tb_piso_serializer.sv
// ---------------------------------------------------------------------------
// tb_piso_serializer
// Self-checking bench for piso_serializer (D_SIZE=4, MSB_FIRST=1). The
// reference model is a queue of the bits still owed on the serial line:
// an accepted word appends its bits (plus a parity bit when PISO_PARITY_EN
// is defined), and every clock edge retires the front bit. All expected
// outputs are derived from that queue.
// ---------------------------------------------------------------------------
module tb_piso_serializer;

    localparam int DW  = 4;
    localparam bit MSB = 1'b1;

    logic          clk;
    logic          rst;
    logic [DW-1:0] in_data;
    logic          in_valid;
    logic          in_ready;
    logic          serial_out;
    logic          serial_valid;
    logic          frame_done;

    int            total;
    int            bad;
    bit            modelQ[$];
    logic [DW-1:0] sipo;

    piso_serializer #(
        .D_SIZE    (DW),
        .MSB_FIRST (MSB)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .in_data      (in_data),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .serial_out   (serial_out),
        .serial_valid (serial_valid),
        .frame_done   (frame_done)
    );

    // Free-running 10-time-unit clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard ceiling on run time in case something stalls outside the
    // bounded loops below.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "[TB] watchdog");
    end

    // Single-bit comparison with failure accounting.
    task automatic checkBit(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Compare all outputs against what the bit queue says should be on the
    // line this cycle.
    task automatic checkOutput();
        logic expValid;
        logic expOut;
        logic expDone;
        logic expReady;
        expValid = (modelQ.size() > 0);
        expOut   = (modelQ.size() > 0) ? modelQ[0] : 1'b0;
        expDone  = (modelQ.size() == 1);
        expReady = !rst && (modelQ.size() <= 1);
        checkBit("serial_valid", serial_valid, expValid);
        checkBit("serial_out",   serial_out,   expOut);
        checkBit("frame_done",   frame_done,   expDone);
        checkBit("in_ready",     in_ready,     expReady);
    endtask

    // Append the bits an accepted word contributes to the line.
    task automatic pushWord(input logic [DW-1:0] w);
        for (int i = 0; i < DW; i++) begin
            modelQ.push_back(MSB ? w[DW-1-i] : w[i]);
        end
`ifdef PISO_PARITY_EN
        modelQ.push_back(^w);
`endif
    endtask

    // One clock cycle: drive inputs just after the falling edge, check,
    // capture the serial bit into a bench-side SIPO, then advance the model
    // across the rising edge. dutAcc reports whether the DUT offered ready.
    task automatic applyStimulus(input logic v, input logic [DW-1:0] d, output bit dutAcc);
        bit modelAcc;
        in_valid = v;
        in_data  = d;
        #1;
        checkOutput();
        modelAcc = v && (modelQ.size() <= 1);
        dutAcc   = v && (in_ready === 1'b1);
        if (serial_valid === 1'b1) begin
            sipo = {sipo[DW-2:0], serial_out};
        end
        @(posedge clk);
        if (modelQ.size() > 0) begin
            void'(modelQ.pop_front());
        end
        if (modelAcc) begin
            pushWord(d);
        end
        @(negedge clk);
    endtask

    // Offer a word and hold it until the DUT takes it.
    task automatic sendWord(input logic [DW-1:0] w);
        bit acc;
        int n;
        acc = 1'b0;
        n   = 0;
        while (!acc && n < 20) begin
            applyStimulus(1'b1, w, acc);
            n++;
        end
        total++;
        assert (acc) else begin
            bad++;
            $error("FAIL accept_timeout observed=%b expected=1 word=%b", acc, w);
        end
    endtask

    // Idle the input until the model has nothing left on the line.
    task automatic drainLine();
        bit acc;
        int n;
        n = 0;
        while (modelQ.size() > 0 && n < 20) begin
            applyStimulus(1'b0, '0, acc);
            n++;
        end
        applyStimulus(1'b0, '0, acc);
    endtask

    initial begin
        bit            acc;
        logic [DW-1:0] rndData;
        logic          rndValid;

        total    = 0;
        bad      = 0;
        sipo     = '0;
        rst      = 1'b1;
        in_valid = 1'b0;
        in_data  = '0;

        // Reset held for 20 time units; everything must be quiet.
        $display("[TB] reset");
        #20;
        checkBit("rst_serial_out",   serial_out,   1'b0);
        checkBit("rst_serial_valid", serial_valid, 1'b0);
        checkBit("rst_frame_done",   frame_done,   1'b0);
        checkBit("rst_in_ready",     in_ready,     1'b0);
        rst = 1'b0;
        #1;
        checkOutput();

        // Single word; the bench SIPO must hold it after four data bits.
        $display("[TB] single word");
        sendWord(4'b1011);
        for (int i = 0; i < DW; i++) begin
            applyStimulus(1'b0, '0, acc);
        end
        total++;
        assert (sipo === 4'b1011) else begin
            bad++;
            $error("FAIL sipo_word observed=%b expected=%b", sipo, 4'b1011);
        end
        drainLine();

        // Back-to-back words with valid held.
        $display("[TB] back-to-back");
        sendWord(4'b1011);
        sendWord(4'b0110);
        drainLine();

        // Backpressure: second word offered mid-frame must wait its turn.
        $display("[TB] backpressure");
        sendWord(4'b0001);
        sendWord(4'b1111);
        drainLine();

        // Parity-sensitive word (even parity 0).
        sendWord(4'b1001);
        drainLine();

        // Reset two bits into a frame aborts it immediately.
        $display("[TB] mid-frame reset");
        sendWord(4'b1100);
        applyStimulus(1'b0, '0, acc);
        applyStimulus(1'b0, '0, acc);
        rst      = 1'b1;
        in_valid = 1'b0;
        #1;
        modelQ.delete();
        checkOutput();
        @(posedge clk);
        @(negedge clk);
        checkOutput();
        rst = 1'b0;
        #1;
        checkOutput();
        sendWord(4'b0101);
        drainLine();

        // Random traffic.
        $display("[TB] random traffic");
        for (int i = 0; i < 300; i++) begin
            rndData  = DW'($urandom);
            rndValid = 1'($urandom_range(0, 1));
            applyStimulus(rndValid, rndData, acc);
        end
        drainLine();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
